// File: rtl/mem_port_arbiter_if.sv
// Avalon read/write master control and user ports shared by mem_port_arbiter.
// The master modport is the arbiter side; the slave modport is the memory master side.
interface mem_port_arbiter_if #(
  parameter int ADDRESSWIDTH = 28,
  parameter int DATAWIDTH    = 32
);
  logic                    read_control_go;
  logic [ADDRESSWIDTH-1:0] read_control_read_base;
  logic [ADDRESSWIDTH-1:0] read_control_read_length;
  logic                    read_control_fixed_location;
  logic                    read_control_done;
  logic                    read_user_read_buffer;
  logic [DATAWIDTH-1:0]    read_user_buffer_output_data;
  logic                    read_user_data_available;

  logic                    write_control_go;
  logic [ADDRESSWIDTH-1:0] write_control_write_base;
  logic [ADDRESSWIDTH-1:0] write_control_write_length;
  logic                    write_control_fixed_location;
  logic                    write_control_done;
  logic                    write_user_write_buffer;
  logic [DATAWIDTH-1:0]    write_user_buffer_data;
  logic                    write_user_buffer_full;

  modport master (
    output read_control_go, read_control_read_base, read_control_read_length,
           read_control_fixed_location, read_user_read_buffer,
           write_control_go, write_control_write_base, write_control_write_length,
           write_control_fixed_location, write_user_write_buffer, write_user_buffer_data,
    input  read_control_done, read_user_buffer_output_data, read_user_data_available,
           write_control_done, write_user_buffer_full
  );

  modport slave (
    input  read_control_go, read_control_read_base, read_control_read_length,
           read_control_fixed_location, read_user_read_buffer,
           write_control_go, write_control_write_base, write_control_write_length,
           write_control_fixed_location, write_user_write_buffer, write_user_buffer_data,
    output read_control_done, read_user_buffer_output_data, read_user_data_available,
           write_control_done, write_user_buffer_full
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one Avalon read master and one write master among NUM_REQ
// single-word requesters. Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDRESSWIDTH = 28,
  parameter int DATAWIDTH    = 32,
  parameter int TIMEOUT      = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              we,
  input  logic [NUM_REQ*ADDRESSWIDTH-1:0] addr,
  input  logic [NUM_REQ*DATAWIDTH-1:0]    wdata,
  output logic [NUM_REQ-1:0]              ack,
  output logic [DATAWIDTH-1:0]            rdata,
  output logic                            err,
  output logic                            busy,
  output logic [1:0]                      grant_id,
  mem_port_arbiter_if.master              mem
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_GO   = 3'd1,
    RD_WAIT = 3'd2,
    RD_ACK  = 3'd3,
    WR_GO   = 3'd4,
    WR_WAIT = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [ADDRESSWIDTH-1:0] LEN_BYTES = ADDRESSWIDTH'(4);
  localparam logic [DATAWIDTH-1:0]    BAD_DATA  = DATAWIDTH'(32'hBAD1BAD1);

  state_t                  state_r, state_s;
  logic [1:0]              ptr_r, ptr_s;
  logic [1:0]              grant_r, grant_s;
  logic [ADDRESSWIDTH-1:0] addr_r, addr_s;
  logic [DATAWIDTH-1:0]    wdata_r, wdata_s;
  logic [DATAWIDTH-1:0]    rdata_r, rdata_s;
  logic                    wr_issue_r, wr_issue_s;
  logic                    err_r, err_s;
  logic [NUM_REQ-1:0]      ack_r, ack_s;
  logic                    rd_go_r, rd_buf_r, busy_r;
  logic [3:0]              req_pad_s, we_pad_s;
  logic [2:0]              idx_s;
  logic [1:0]              pick_s;
  logic                    found_s;
  logic                    to_s;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_r;
  logic          counting_s;

  assign counting_s = (state_r == RD_WAIT) || (state_r == WR_GO) || (state_r == WR_WAIT);
  assign to_s       = counting_s && (cnt_r >= CW'(TIMEOUT - 1));

  // Watchdog counter: cleared while arbitrating, advances in the waiting states.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= CW'(0);
    end else if (state_r == IDLE) begin
      cnt_r <= CW'(0);
    end else if (counting_s) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  assign to_s = 1'b0;
`endif

  // Rotating search for the first requester at or after ptr_r.
  always_comb begin
    req_pad_s                = 4'd0;
    we_pad_s                 = 4'd0;
    req_pad_s[NUM_REQ-1:0]   = req;
    we_pad_s[NUM_REQ-1:0]    = we;
    pick_s                   = 2'd0;
    found_s                  = 1'b0;
    idx_s                    = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = {1'b0, ptr_r} + 3'(i);
      if (idx_s >= 3'(NUM_REQ)) begin
        idx_s = idx_s - 3'(NUM_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req_pad_s[idx_s[1:0]]) begin
        found_s = 1'b1;
        pick_s  = idx_s[1:0];
      end else begin
        found_s = found_s;
        pick_s  = pick_s;
      end
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    grant_s    = grant_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    rdata_s    = rdata_r;
    wr_issue_s = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          grant_s = pick_s;
          addr_s  = addr[int'(pick_s)*ADDRESSWIDTH +: ADDRESSWIDTH];
          wdata_s = wdata[int'(pick_s)*DATAWIDTH +: DATAWIDTH];
          ptr_s   = (pick_s == 2'(NUM_REQ - 1)) ? 2'd0 : pick_s + 2'd1;
          if (we_pad_s[pick_s]) begin
            state_s    = WR_GO;
            wr_issue_s = !mem.write_user_buffer_full;
          end else begin
            state_s = RD_GO;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD_GO: state_s = RD_WAIT;
      RD_WAIT: begin
        if (to_s) begin
          state_s = DONE;
          err_s   = 1'b1;
          rdata_s = BAD_DATA;
        end else if (mem.read_control_done && mem.read_user_data_available) begin
          state_s = RD_ACK;
        end else begin
          state_s = RD_WAIT;
        end
      end
      RD_ACK: begin
        rdata_s = mem.read_user_buffer_output_data;
        state_s = DONE;
      end
      // Strobes are issued from a registered view of buffer_full, so they never
      // depend combinationally on the master.
      WR_GO: begin
        if (wr_issue_r) begin
          state_s = WR_WAIT;
        end else if (to_s) begin
          state_s = DONE;
          err_s   = 1'b1;
          rdata_s = BAD_DATA;
        end else begin
          state_s    = WR_GO;
          wr_issue_s = !mem.write_user_buffer_full;
        end
      end
      WR_WAIT: begin
        if (to_s) begin
          state_s = DONE;
          err_s   = 1'b1;
          rdata_s = BAD_DATA;
        end else if (mem.write_control_done) begin
          state_s = DONE;
        end else begin
          state_s = WR_WAIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    if (state_s == DONE) begin
      ack_s = NUM_REQ'(1) << grant_r;
    end else begin
      ack_s = NUM_REQ'(0);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      ptr_r      <= 2'd0;
      grant_r    <= 2'd0;
      addr_r     <= ADDRESSWIDTH'(0);
      wdata_r    <= DATAWIDTH'(0);
      rdata_r    <= DATAWIDTH'(0);
      wr_issue_r <= 1'b0;
      err_r      <= 1'b0;
      ack_r      <= NUM_REQ'(0);
      rd_go_r    <= 1'b0;
      rd_buf_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      grant_r    <= grant_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
      rdata_r    <= rdata_s;
      wr_issue_r <= wr_issue_s;
      err_r      <= err_s;
      ack_r      <= ack_s;
      rd_go_r    <= (state_s == RD_GO);
      rd_buf_r   <= (state_s == RD_ACK);
      busy_r     <= (state_s != IDLE);
    end
  end

  assign ack      = ack_r;
  assign rdata    = rdata_r;
  assign err      = err_r;
  assign busy     = busy_r;
  assign grant_id = grant_r;

  assign mem.read_control_go              = rd_go_r;
  assign mem.read_control_read_base       = addr_r;
  assign mem.read_control_read_length     = LEN_BYTES;
  assign mem.read_control_fixed_location  = 1'b1;
  assign mem.read_user_read_buffer        = rd_buf_r;
  assign mem.write_control_go             = wr_issue_r;
  assign mem.write_control_write_base     = addr_r;
  assign mem.write_control_write_length   = LEN_BYTES;
  assign mem.write_control_fixed_location = 1'b1;
  assign mem.write_user_write_buffer      = wr_issue_r;
  assign mem.write_user_buffer_data       = wdata_r;

endmodule
